// File: rtl/fns_enc_38_seq_pkg.sv
// ----------------------------------------------------------------------------
// fns_enc_38_seq_pkg
// Shared constants for the 38-bit Fibonacci-numeral-system (FNS) encoder.
//   FNS_CW     codeword width (number of FNS weights)
//   FNS_DW     binary data width; holds the sum of all weights
//   FNS_MAX38  largest encodable value (sum of all 38 weights)
//   FNS_W      weight table, element k = W[k] (W[0]=W[1]=1, W[k]=W[k-1]+W[k-2])
//   ST_*       encoder FSM state encodings
// Optional feature macro: FNS_ENC_RANGE_CHK_EN (used by fns_enc_38_seq).
// ----------------------------------------------------------------------------
package fns_enc_38_seq_pkg;

    localparam int unsigned FNS_CW = 38;
    localparam int unsigned FNS_DW = 27;

    localparam logic [FNS_DW-1:0] FNS_MAX38 = 27'd102334154;

    // Listed MSB-first so that FNS_W[k] is weight k.
    localparam logic [FNS_CW-1:0][FNS_DW-1:0] FNS_W = {
        27'd39088169, 27'd24157817, 27'd14930352, 27'd9227465,
        27'd5702887,  27'd3524578,  27'd2178309,  27'd1346269,
        27'd832040,   27'd514229,   27'd317811,   27'd196418,
        27'd121393,   27'd75025,    27'd46368,    27'd28657,
        27'd17711,    27'd10946,    27'd6765,     27'd4181,
        27'd2584,     27'd1597,     27'd987,      27'd610,
        27'd377,      27'd233,      27'd144,      27'd89,
        27'd55,       27'd34,       27'd21,       27'd13,
        27'd8,        27'd5,        27'd3,        27'd2,
        27'd1,        27'd1
    };

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic logic fns_in_range(input logic [FNS_DW-1:0] value);
        return value <= FNS_MAX38;
    endfunction

endpackage

// File: rtl/fns_enc_38_seq_weight_rom.sv
// ----------------------------------------------------------------------------
// fns_weight_rom
// Combinational FNS weight lookup: idx -> W[idx]. Indices beyond the
// codeword width return 0.
//   idx_i     in   6        weight index
//   weight_o  out  FNS_DW   weight value
// ----------------------------------------------------------------------------
module fns_weight_rom
    import fns_enc_38_seq_pkg::*;
(
    input  logic [5:0]        idx_i,
    output logic [FNS_DW-1:0] weight_o
);

    always_comb begin
        weight_o = '0;
        if (idx_i < 6'(FNS_CW)) begin
            weight_o = FNS_W[idx_i];
        end
    end

endmodule

// File: rtl/fns_enc_38_seq.sv
// ----------------------------------------------------------------------------
// fns_enc_38_seq
// Sequential FNS encoder: binary word -> 38-bit FNS codeword. Greedy,
// MSB-first, one weight compared per clock; valid/ready on both sides.
// Optional feature macro: FNS_ENC_RANGE_CHK_EN (flag out-of-range inputs
// on err and force an all-zero codeword; otherwise err stays 0).
//   clk        in   1       clock, rising edge
//   rst_n      in   1       asynchronous active-low reset
//   datain     in   27      binary value to encode
//   in_valid   in   1       datain valid
//   in_ready   out  1       encoder idle and accepting
//   codeout    out  38      FNS codeword, bit k carries weight W[k]
//   out_valid  out  1       codeout valid, held until out_ready
//   out_ready  in   1       downstream accepts codeout
//   err        out  1       out-of-range flag, qualified by out_valid
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for in_valid; in_ready high
// RUN     | one weight per cycle, idx counts 37 down to 0
// DONE    | codeword presented with out_valid until out_ready
// ----------------------------------------------------------------------------
module fns_enc_38_seq
    import fns_enc_38_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [FNS_DW-1:0] datain,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [FNS_CW-1:0] codeout,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              err
);

    logic [1:0]        state_q, state_d;
    logic [5:0]        idx_q, idx_d;
    logic [FNS_DW-1:0] rem_q, rem_d;
    logic [FNS_CW-1:0] code_q, code_d;
    logic              err_q, err_d;
    logic [FNS_DW-1:0] weight;
    logic              accept_err;

    fns_weight_rom u_rom (
        .idx_i    (idx_q),
        .weight_o (weight)
    );

`ifdef FNS_ENC_RANGE_CHK_EN
    assign accept_err = !fns_in_range(datain);
`else
    assign accept_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rem_d   = rem_q;
        code_d  = code_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    rem_d   = datain;
                    idx_d   = 6'(FNS_CW - 1);
                    code_d  = '0;
                    err_d   = accept_err;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // A flagged input still walks all weights so latency is
                // constant, but never sets a codeword bit.
                if (!err_q && (rem_q >= weight)) begin
                    code_d[idx_q] = 1'b1;
                    rem_d         = rem_q - weight;
                end
                if (idx_q == 6'd0) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q - 6'd1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            rem_q   <= '0;
            code_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rem_q   <= rem_d;
            code_q  <= code_d;
            err_q   <= err_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign codeout   = code_q;
    assign err       = err_q;

endmodule
